// File: rtl/perip_responder_pkg.sv
// Shared address map, access-size encodings and lane helpers for the perip_* bus.
package perip_responder_pkg;

  localparam logic [31:0] PMAP_DRAM_BASE = 32'h8010_0000;
  localparam logic [31:0] PMAP_MMIO_BASE = 32'h8020_0000;

  typedef enum logic [1:0] {
    MASK_B = 2'b00,
    MASK_H = 2'b01,
    MASK_W = 2'b10,
    MASK_R = 2'b11
  } mask_e;

  // Word offsets inside the 32-byte MMIO window (addr[4:2]).
  typedef enum logic [2:0] {
    MMIO_SW    = 3'd0,
    MMIO_LED   = 3'd1,
    MMIO_TCTRL = 3'd2,
    MMIO_TCNT  = 3'd3,
    MMIO_CYCLE = 3'd4
  } mmio_reg_e;

  localparam int unsigned TCTRL_EN_BIT  = 0;
  localparam int unsigned TCTRL_CLR_BIT = 1;

  // True when a store of this size cannot be placed at this byte offset.
  function automatic logic is_misaligned(input mask_e m, input logic [1:0] a);
    case (m)
      MASK_B:  return 1'b0;
      MASK_H:  return a[0];
      MASK_W:  return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Byte-lane enables for an aligned store of the given size.
  function automatic logic [3:0] lane_be(input mask_e m, input logic [1:0] a);
    case (m)
      MASK_B:  return 4'b0001 << a;
      MASK_H:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/perip_timer.sv
// Prescaled timer: prescaler advances while enabled, TCNT bumps on each wrap.
module perip_timer #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        en,
  input  logic        clr,
  output logic [31:0] cnt
);

  localparam logic [31:0] PRE_LAST = 32'(PRESCALE - 1);

  logic [31:0] r_pre;
  logic [31:0] r_cnt;

  // Clear has priority over a coincident tick; prescaler holds while disabled.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (en) begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        r_cnt <= r_cnt + 32'd1;
      end else begin
        r_pre <= r_pre + 32'd1;
      end
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/perip_responder.sv
// Responder for the core's perip_* load/store port: DRAM window plus MMIO block.
module perip_responder
  import perip_responder_pkg::*;
#(
  parameter logic [31:0] DRAM_BASE      = PMAP_DRAM_BASE,
  parameter int unsigned DRAM_AW        = 16,
  parameter logic [31:0] MMIO_BASE      = PMAP_MMIO_BASE,
  parameter int unsigned TIMER_PRESCALE = 1000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] perip_addr,
  input  logic        perip_wen,
  input  logic [1:0]  perip_mask,
  input  logic [31:0] perip_wdata,
  output logic [31:0] perip_rdata,
  input  logic [31:0] sw_in,
  output logic [31:0] led_out,
  output logic        err_misalign
);

  logic [31:0]        r_dram [2**DRAM_AW];
  logic [31:0]        r_rdata;
  logic [31:0]        r_led;
  logic               r_tctrl_en;
  logic [31:0]        r_cycle;
  logic [31:0]        r_sw_s1;
  logic [31:0]        r_sw_s2;
  logic               r_err;

  logic [31:0]        w_dram_off;
  logic               w_dram_hit;
  logic               w_mmio_hit;
  logic [DRAM_AW-1:0] w_word_idx;
  mask_e              w_mask;
  logic               w_misalign;
  logic               w_store_ok;
  logic [3:0]         w_be;
  logic [31:0]        w_wlane;
  logic               w_dram_we;
  logic               w_mmio_word_we;
  logic               w_led_we;
  logic               w_tctrl_we;
  logic               w_clr;
  logic [31:0]        w_tcnt;
  logic [31:0]        w_rd_word;

  assign w_dram_off     = perip_addr - DRAM_BASE;
  assign w_dram_hit     = (perip_addr >= DRAM_BASE) && ((w_dram_off >> (DRAM_AW + 2)) == '0);
  assign w_mmio_hit     = perip_addr[31:5] == MMIO_BASE[31:5];
  assign w_word_idx     = w_dram_off[DRAM_AW+1:2];
  assign w_mask         = mask_e'(perip_mask);
  assign w_misalign     = is_misaligned(w_mask, perip_addr[1:0]);
  assign w_store_ok     = perip_wen && !w_misalign;
  assign w_be           = lane_be(w_mask, perip_addr[1:0]);
  assign w_wlane        = (w_mask == MASK_B) ? {4{perip_wdata[7:0]}}  :
                          (w_mask == MASK_H) ? {2{perip_wdata[15:0]}} : perip_wdata;
  assign w_dram_we      = w_store_ok && w_dram_hit;
  assign w_mmio_word_we = w_store_ok && w_mmio_hit && (w_mask == MASK_W);
  assign w_led_we       = w_mmio_word_we && (perip_addr[4:2] == MMIO_LED);
  assign w_tctrl_we     = w_mmio_word_we && (perip_addr[4:2] == MMIO_TCTRL);
  assign w_clr          = w_tctrl_we && perip_wdata[TCTRL_CLR_BIT];

  // Word-organised data RAM with per-byte write enables; contents are never reset.
  always_ff @(posedge cpu_clk) begin
    if (w_dram_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_dram[w_word_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

  // Read mux over current (pre-store) state; unmapped and reserved offsets read zero.
  always_comb begin
    w_rd_word = '0;
    if (w_dram_hit) begin
      w_rd_word = r_dram[w_word_idx];
    end else if (w_mmio_hit) begin
      case (mmio_reg_e'(perip_addr[4:2]))
        MMIO_SW:    w_rd_word = r_sw_s2;
        MMIO_LED:   w_rd_word = r_led;
        MMIO_TCTRL: w_rd_word[TCTRL_EN_BIT] = r_tctrl_en;
        MMIO_TCNT:  w_rd_word = w_tcnt;
        MMIO_CYCLE: w_rd_word = r_cycle;
        default:    w_rd_word = '0;
      endcase
    end
  end

  // Registered load data, MMIO registers, switch synchroniser and error pulse.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_rdata    <= '0;
      r_led      <= '0;
      r_tctrl_en <= 1'b0;
      r_cycle    <= '0;
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rdata <= w_rd_word;
      r_cycle <= r_cycle + 32'd1;
      r_sw_s1 <= sw_in;
      r_sw_s2 <= r_sw_s1;
      r_err   <= perip_wen && w_misalign && (w_dram_hit || w_mmio_hit);
      if (w_led_we)   r_led      <= perip_wdata;
      if (w_tctrl_we) r_tctrl_en <= perip_wdata[TCTRL_EN_BIT];
    end
  end

  perip_timer #(
    .PRESCALE(TIMER_PRESCALE)
  ) u_timer (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .en     (r_tctrl_en),
    .clr    (w_clr),
    .cnt    (w_tcnt)
  );

  assign perip_rdata  = r_rdata;
  assign led_out      = r_led;
  assign err_misalign = r_err;

endmodule

// File: tb/tb_perip_responder.sv
// Directed bench for perip_responder with a load-data scoreboard.
module tb_perip_responder;
  import perip_responder_pkg::*;

  localparam logic [31:0] D = 32'h8010_0000;
  localparam logic [31:0] M = 32'h8020_0000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic [31:0] perip_addr = '0;
  logic        perip_wen = 1'b0;
  logic [1:0]  perip_mask = '0;
  logic [31:0] perip_wdata = '0;
  logic [31:0] perip_rdata;
  logic [31:0] sw_in = '0;
  logic [31:0] led_out;
  logic        err_misalign;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] q_exp[$];
  string       q_tag[$];

  perip_responder #(
    .DRAM_AW       (8),
    .TIMER_PRESCALE(4)
  ) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .perip_addr  (perip_addr),
    .perip_wen   (perip_wen),
    .perip_mask  (perip_mask),
    .perip_wdata (perip_wdata),
    .perip_rdata (perip_rdata),
    .sw_in       (sw_in),
    .led_out     (led_out),
    .err_misalign(err_misalign)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle; a checked load pushes its expectation, popped after the edge.
  task automatic step(input logic [31:0] addr, input logic wen, input logic [1:0] mask,
                      input logic [31:0] wdata, input logic rd_chk,
                      input logic [31:0] exp, input string tag);
    perip_addr  = addr;
    perip_wen   = wen;
    perip_mask  = mask;
    perip_wdata = wdata;
    if (rd_chk) begin
      q_exp.push_back(exp);
      q_tag.push_back(tag);
    end
    @(posedge cpu_clk);
    #1;
    perip_wen = 1'b0;
    if (q_exp.size() > 0) chk(q_tag.pop_front(), perip_rdata, q_exp.pop_front());
  endtask

  task automatic wr(input logic [31:0] addr, input logic [1:0] mask, input logic [31:0] data);
    step(addr, 1'b1, mask, data, 1'b0, '0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    step(addr, 1'b0, MASK_W, '0, 1'b1, exp, tag);
  endtask

  task automatic idle();
    step(32'h0, 1'b0, MASK_W, '0, 1'b0, '0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge cpu_clk);
    #1;
    chk("reset_rdata", perip_rdata, 32'h0);
    chk("reset_led", led_out, 32'h0);
    chk("reset_err", {31'b0, err_misalign}, 32'h0);
    @(negedge cpu_clk);
    cpu_rst = 1'b1;

    // Word store then load
    wr(D + 32'h10, MASK_W, 32'hDEAD_BEEF);
    chk("err_good_store", {31'b0, err_misalign}, 32'h0);
    rd(D + 32'h10, 32'hDEAD_BEEF, "t1_word");

    // Byte and half lane steering
    wr(D + 32'h11, MASK_B, 32'hFFFF_FFAA);
    wr(D + 32'h12, MASK_H, 32'hABCD_1234);
    rd(D + 32'h10, 32'h1234_AAEF, "t2_lanes");
    rd(D + 32'h13, 32'h1234_AAEF, "t2_unaligned_read");

    // Misaligned and reserved-size stores
    wr(D + 32'h13, MASK_H, 32'h0000_5555);
    chk("t3_err_half", {31'b0, err_misalign}, 32'h1);
    wr(D + 32'h12, MASK_W, 32'h0);
    chk("t3_err_word", {31'b0, err_misalign}, 32'h1);
    wr(D + 32'h10, MASK_R, 32'h0);
    chk("t3_err_rsvd", {31'b0, err_misalign}, 32'h1);
    rd(D + 32'h10, 32'h1234_AAEF, "t3_unchanged");
    chk("t3_err_clear", {31'b0, err_misalign}, 32'h0);

    // Read-before-write on the same word
    wr(D + 32'h20, MASK_W, 32'h1111_1111);
    step(D + 32'h20, 1'b1, MASK_W, 32'h2222_2222, 1'b1, 32'h1111_1111, "rbw_old");
    rd(D + 32'h20, 32'h2222_2222, "rbw_new");

    // DRAM window edges
    wr(D, MASK_W, 32'hA5A5_A5A5);
    wr(D + 32'h3FC, MASK_W, 32'hC3C3_C3C3);
    wr(D + 32'h400, MASK_W, 32'hFFFF_FFFF);
    chk("past_end_no_err", {31'b0, err_misalign}, 32'h0);
    rd(D + 32'h400, 32'h0, "dram_past_end");
    rd(D + 32'h3FC, 32'hC3C3_C3C3, "dram_last");
    rd(D, 32'hA5A5_A5A5, "dram_no_alias");

    // LED register
    step(M + 32'h4, 1'b1, MASK_W, 32'h5, 1'b1, 32'h0, "led_rbw");
    chk("led_out", led_out, 32'h5);
    wr(M + 32'h4, MASK_B, 32'hFF);
    chk("led_byte_err", {31'b0, err_misalign}, 32'h0);
    chk("led_byte_ignored", led_out, 32'h5);
    rd(M + 32'h4, 32'h5, "led_read");

    // Reserved MMIO offsets
    wr(M + 32'h14, MASK_W, 32'hFFFF_FFFF);
    rd(M + 32'h14, 32'h0, "mmio_rsvd14");
    rd(M + 32'h1C, 32'h0, "mmio_rsvd1c");

    // Timer with prescale 4
    wr(M + 32'h8, MASK_W, 32'h1);
    repeat (40) idle();
    rd(M + 32'hC, 32'd10, "t4_tcnt10");
    rd(M + 32'h8, 32'h1, "t4_tctrl");
    idle();
    wr(M + 32'h8, MASK_W, 32'h3);
    rd(M + 32'hC, 32'h0, "t4_clr");
    idle();
    idle();
    rd(M + 32'hC, 32'h0, "t4_restart_pre");
    rd(M + 32'hC, 32'h1, "t4_restart_tick");
    rd(M + 32'h8, 32'h1, "t4_en_kept");
    wr(M + 32'h8, MASK_W, 32'h0);
    repeat (8) idle();
    rd(M + 32'hC, 32'h1, "timer_hold");
    wr(M + 32'h8, MASK_W, 32'h1);
    rd(M + 32'hC, 32'h1, "timer_resume_pre");
    rd(M + 32'hC, 32'h2, "timer_resume_tick");

    // Unmapped access
    rd(32'h0000_1000, 32'h0, "t5_unmapped_read");
    wr(32'h0000_1000, MASK_W, 32'h77);
    chk("t5_unmapped_err", {31'b0, err_misalign}, 32'h0);
    chk("t5_led_intact", led_out, 32'h5);
    rd(D + 32'h10, 32'h1234_AAEF, "t5_dram_intact");

    // Reset in the middle of a load
    perip_addr = D + 32'h10;
    perip_mask = MASK_W;
    #3;
    cpu_rst = 1'b0;
    #1;
    chk("t6_rst_rdata", perip_rdata, 32'h0);
    chk("t6_rst_led", led_out, 32'h0);
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    rd(M + 32'h10, 32'h0, "t6_cycle0");
    rd(M + 32'h10, 32'h1, "t6_cycle1");
    rd(M + 32'h4, 32'h0, "t6_led_read");
    rd(M + 32'hC, 32'h0, "t6_tcnt");
    rd(M + 32'h8, 32'h0, "t6_tctrl");

    // Switch synchroniser delay
    sw_in = 32'h0000_F0F0;
    rd(M, 32'h0, "sw_c1");
    rd(M, 32'h0, "sw_c2");
    rd(M, 32'h0000_F0F0, "sw_c3");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
